rf_spi_responder: RTL and testbench

RF_SPI_RESPONDER -- requirements
Module: rf_spi_responder

---
 rtl/rf_spi_responder_if.sv | 18 +
 rtl/rf_spi_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_rf_spi_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_spi_responder_if.sv
// SPI pins, event inputs, interrupt and write-strobe bus of the SPI register responder.
interface rf_spi_responder_if;
  logic       sck;
  logic       cs;
  logic       sdi;
  logic       sdo;
  logic [7:0] ev_in;
  logic       intr;
  logic       wr_valid;
  logic       wr_long;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output sck, cs, sdi, ev_in,
                  input  sdo, intr, wr_valid, wr_long, wr_addr, wr_data);
  modport slave  (input  sck, cs, sdi, ev_in,
                  output sdo, intr, wr_valid, wr_long, wr_addr, wr_data);
endinterface

// File: rtl/rf_spi_responder.sv
// SPI register responder: 64x8 short bank plus 1024x8 long bank, interrupt-status register,
// all SPI pins oversampled in the clk domain.
module rf_spi_responder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [5:0]  INTSTAT_ADDR = 6'h31
) (
  input logic              clk,
  input logic              rst_n,
  rf_spi_responder_if.slave spi
);
  localparam int unsigned DW    = 8;
  localparam int unsigned SAW   = 6;
  localparam int unsigned LAW   = 10;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned CMDW  = 10;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_PAD, S_DATA, S_DONE} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CMDW-1:0] cmd_q, cmd_d;
  logic [CMDW:0]   cmd_full;
  logic            long_q, long_d;
  logic            we_q, we_d;
  logic [LAW-1:0]  addr_q, addr_d;
  logic [DW-2:0]   wsh_q, wsh_d;
  logic [DW-1:0]   wsh_full;
  logic [DW-1:0]   rsh_q, rsh_d;
  logic            sdo_q, sdo_d;
  logic            wr_valid_q, wr_valid_d;
  logic            wr_long_q, wr_long_d;
  logic [LAW-1:0]  wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [DW-1:0]   intstat_q, intstat_d;
  logic            intr_q, intr_d;
  logic            enter_data, clr_int;
  logic [DW-1:0]   rd_byte;

  logic [DW-1:0] short_mem [2**SAW];
  logic [DW-1:0] long_mem  [2**LAW];

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
  // cs synchroniser resets low so a frame left open across reset is never re-entered
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cmd_full = {cmd_q, sdi_s};
  assign wsh_full = {wsh_q, sdi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '0;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi.sck};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi.sdi};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      long_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wsh_q      <= '0;
      rsh_q      <= '0;
      sdo_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_long_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      intstat_q  <= '0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      long_q     <= long_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wsh_q      <= wsh_d;
      rsh_q      <= rsh_d;
      sdo_q      <= sdo_d;
      wr_valid_q <= wr_valid_d;
      wr_long_q  <= wr_long_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      intstat_q  <= intstat_d;
      intr_q     <= intr_d;
    end
  end

  // Bank write lands on the same edge that raises wr_valid
  always_ff @(posedge clk) begin
    if (wr_valid_d) begin
      if (wr_long_d) long_mem[wr_addr_d] <= wr_data_d;
      else           short_mem[wr_addr_d[SAW-1:0]] <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    long_d     = long_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wsh_d      = wsh_q;
    rsh_d      = rsh_q;
    sdo_d      = sdo_q;
    wr_valid_d = 1'b0;
    wr_long_d  = wr_long_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    enter_data = 1'b0;
    clr_int    = 1'b0;
    rd_byte    = '0;

    case (state_q)
      S_IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        sdo_d = 1'b0;
        if (sck_rise) begin
          cmd_d = cmd_full[CMDW-1:0];
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == '0) long_d = sdi_s;
          if (!long_q && cnt_q == CNTW'(7)) begin
            state_d    = S_DATA;
            cnt_d      = '0;
            addr_d     = {4'b0000, cmd_full[SAW:1]};
            we_d       = cmd_full[0];
            enter_data = 1'b1;
          end else if (long_q && cnt_q == CNTW'(11)) begin
            state_d = S_PAD;
            cnt_d   = '0;
            addr_d  = cmd_full[LAW:1];
            we_d    = cmd_full[0];
          end
        end
      end
      S_PAD: begin
        sdo_d = 1'b0;
        if (sck_rise) begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(3)) begin
            state_d    = S_DATA;
            cnt_d      = '0;
            enter_data = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sck_fall) begin
          sdo_d = rsh_q[DW-1];
          rsh_d = {rsh_q[DW-2:0], 1'b0};
        end
        if (sck_rise) begin
          wsh_d = wsh_full[DW-2:0];
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(7)) begin
            state_d = S_DONE;
            sdo_d   = 1'b0;
            if (we_q) begin
              wr_valid_d = 1'b1;
              wr_long_d  = long_q;
              wr_addr_d  = addr_q;
              wr_data_d  = wsh_full;
            end else if (!long_q && addr_q[SAW-1:0] == INTSTAT_ADDR) begin
              clr_int = 1'b1;
            end
          end
        end
      end
      S_DONE:  sdo_d = 1'b0;
      default: state_d = S_IDLE;
    endcase

    // Read data is captured once at DATA entry; write frames shift out zeros
    if (enter_data) begin
      if (long_q)                             rd_byte = long_mem[addr_d];
      else if (addr_d[SAW-1:0] == INTSTAT_ADDR) rd_byte = intstat_q;
      else                                    rd_byte = short_mem[addr_d[SAW-1:0]];
      rsh_d = we_d ? '0 : rd_byte;
    end

    if (cs_rise) begin
      state_d    = S_IDLE;
      sdo_d      = 1'b0;
      wr_valid_d = 1'b0;
      wr_long_d  = wr_long_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      clr_int    = 1'b0;
    end

    // Event bits always survive a clear or an overwrite in the same cycle
    intstat_d = intstat_q | spi.ev_in;
    if (clr_int)
      intstat_d = spi.ev_in;
    else if (wr_valid_d && !wr_long_d && wr_addr_d[SAW-1:0] == INTSTAT_ADDR)
      intstat_d = wr_data_d | spi.ev_in;
    intr_d = |intstat_q;
  end

  assign spi.sdo      = sdo_q;
  assign spi.intr     = intr_q;
  assign spi.wr_valid = wr_valid_q;
  assign spi.wr_long  = wr_long_q;
  assign spi.wr_addr  = wr_addr_q;
  assign spi.wr_data  = wr_data_q;
endmodule

// File: tb/tb_rf_spi_responder.sv
// Self-checking bench for rf_spi_responder: directed scenarios plus randomized frames against a bank model.
module tb_rf_spi_responder;
  localparam int unsigned HALF = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  rf_spi_responder_if bus();

  rf_spi_responder #(.SYNC_STAGES(2), .INTSTAT_ADDR(6'h31)) dut (
    .clk(clk), .rst_n(rst_n), .spi(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Write-strobe monitor
  int         wr_cnt = 0;
  logic       wr_l_seen;
  logic [9:0] wr_a_seen;
  logic [7:0] wr_d_seen;
  always @(negedge clk) begin
    if (rst_n && bus.wr_valid === 1'b1) begin
      wr_cnt++;
      wr_l_seen = bus.wr_long;
      wr_a_seen = bus.wr_addr;
      wr_d_seen = bus.wr_data;
    end
  end

  // Reference model
  logic [7:0] short_m [64];
  logic [7:0] long_m  [1024];
  logic [7:0] intstat_m = 8'h00;
  bit         wq_l [$];
  logic [9:0] wq_a [$];

  function automatic void model_write(input bit lng, input logic [9:0] a, input logic [7:0] d);
    if (lng) long_m[a] = d;
    else if (a[5:0] == 6'h31) intstat_m = d;
    else short_m[a[5:0]] = d;
  endfunction

  function automatic logic [7:0] model_read(input bit lng, input logic [9:0] a);
    logic [7:0] r;
    if (!lng && a[5:0] == 6'h31) begin
      r = intstat_m;
      intstat_m = 8'h00;
    end else begin
      r = lng ? long_m[a] : short_m[a[5:0]];
    end
    return r;
  endfunction

  // SPI mode-0 initiator; ev_tail is held after the last data rise to race the INTSTAT clear
  task automatic spi_frame(input bit lng, input logic [9:0] addr, input bit we,
                           input logic [7:0] wdat, input int ndata, input int extra,
                           input logic [7:0] ev_tail, output logic [7:0] rdat,
                           output bit done_sdo_bad, output bit tail_intr_bad);
    logic [15:0] cmd;
    int ncmd;
    if (lng) begin cmd = {1'b1, addr, we, 4'b0000}; ncmd = 16; end
    else     begin cmd = {1'b0, addr[5:0], we, 8'h00}; ncmd = 8; end
    rdat = '0; done_sdo_bad = 1'b0; tail_intr_bad = 1'b0;
    bus.cs = 1'b0;
    #(2*HALF);
    for (int i = 0; i < ncmd; i++) begin
      bus.sdi = cmd[15-i];
      #HALF bus.sck = 1'b1;
      #HALF bus.sck = 1'b0;
    end
    for (int i = 0; i < ndata; i++) begin
      bus.sdi = wdat[7-i];
      #HALF rdat[7-i] = bus.sdo;
      bus.sck = 1'b1;
      if (i == 7 && ev_tail != 8'h00) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk) bus.ev_in = ev_tail;
          if (bus.intr !== 1'b1) tail_intr_bad = 1'b1;
        end
        @(negedge clk) bus.ev_in = 8'h00;
      end
      #HALF bus.sck = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      #HALF if (bus.sdo !== 1'b0) done_sdo_bad = 1'b1;
      bus.sck = 1'b1;
      #HALF bus.sck = 1'b0;
    end
    #HALF bus.sdi = 1'b0;
    bus.cs = 1'b1;
    #(3*HALF);
  endtask

  task automatic pulse_ev(input logic [7:0] v);
    @(negedge clk) bus.ev_in = v;
    @(negedge clk) bus.ev_in = 8'h00;
    @(negedge clk);
    intstat_m = intstat_m | v;
  endtask

  task automatic test_reset;
    bus.cs = 1'b1; bus.sck = 1'b0; bus.sdi = 1'b0; bus.ev_in = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.sdo !== 1'b0)      begin errors++; $display("FAIL reset_sdo: got %b want 0", bus.sdo); end
    checks++; if (bus.intr !== 1'b0)     begin errors++; $display("FAIL reset_intr: got %b want 0", bus.intr); end
    checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); end
    checks++; if (bus.wr_long !== 1'b0)  begin errors++; $display("FAIL reset_wr_long: got %b want 0", bus.wr_long); end
    checks++; if (bus.wr_addr !== 10'h0) begin errors++; $display("FAIL reset_wr_addr: got %h want 000", bus.wr_addr); end
    checks++; if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
    #40 rst_n = 1'b1;
    #100;
  endtask

  task automatic test_short_write_read;
    logic [7:0] r; bit b1, b2; int n0;
    n0 = wr_cnt;
    spi_frame(1'b0, 10'h012, 1'b1, 8'hA5, 8, 0, 8'h00, r, b1, b2);
    model_write(1'b0, 10'h012, 8'hA5);
    checks++; if (wr_cnt !== n0 + 1) begin errors++; $display("FAIL short_wr_count: got %0d want %0d", wr_cnt - n0, 1); end
    checks++; if ({wr_l_seen, wr_a_seen, wr_d_seen} !== {1'b0, 10'h012, 8'hA5})
      begin errors++; $display("FAIL short_wr_fields: got l=%b a=%h d=%h want l=0 a=012 d=a5", wr_l_seen, wr_a_seen, wr_d_seen); end
    spi_frame(1'b0, 10'h012, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    checks++; if (r !== model_read(1'b0, 10'h012)) begin errors++; $display("FAIL short_read: got %h want a5", r); end
  endtask

  task automatic test_long_write_read;
    logic [7:0] r, e; bit b1, b2; int n0;
    spi_frame(1'b0, 10'h03F, 1'b1, 8'h3C, 8, 0, 8'h00, r, b1, b2);
    model_write(1'b0, 10'h03F, 8'h3C);
    n0 = wr_cnt;
    spi_frame(1'b1, 10'h3FF, 1'b1, 8'h5C, 8, 0, 8'h00, r, b1, b2);
    model_write(1'b1, 10'h3FF, 8'h5C);
    checks++; if (wr_cnt !== n0 + 1) begin errors++; $display("FAIL long_wr_count: got %0d want 1", wr_cnt - n0); end
    checks++; if ({wr_l_seen, wr_a_seen, wr_d_seen} !== {1'b1, 10'h3FF, 8'h5C})
      begin errors++; $display("FAIL long_wr_fields: got l=%b a=%h d=%h want l=1 a=3ff d=5c", wr_l_seen, wr_a_seen, wr_d_seen); end
    spi_frame(1'b1, 10'h3FF, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    e = model_read(1'b1, 10'h3FF);
    checks++; if (r !== e) begin errors++; $display("FAIL long_read: got %h want %h", r, e); end
    spi_frame(1'b0, 10'h03F, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    e = model_read(1'b0, 10'h03F);
    checks++; if (r !== e) begin errors++; $display("FAIL short_3f_unaffected: got %h want %h", r, e); end
  endtask

  task automatic test_abort_write;
    logic [7:0] r, e; bit b1, b2; int n0;
    spi_frame(1'b0, 10'h005, 1'b1, 8'h6E, 8, 0, 8'h00, r, b1, b2);
    model_write(1'b0, 10'h005, 8'h6E);
    n0 = wr_cnt;
    spi_frame(1'b0, 10'h005, 1'b1, 8'h91, 3, 0, 8'h00, r, b1, b2);
    checks++; if (wr_cnt !== n0) begin errors++; $display("FAIL abort_no_commit: got %0d pulses want 0", wr_cnt - n0); end
    spi_frame(1'b0, 10'h005, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    e = model_read(1'b0, 10'h005);
    checks++; if (r !== e) begin errors++; $display("FAIL abort_prior_value: got %h want %h", r, e); end
  endtask

  task automatic test_intstat;
    logic [7:0] r, e; bit b1, b2; int n0;
    pulse_ev(8'h04);
    checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL intr_rise: got %b want 1", bus.intr); end
    spi_frame(1'b0, 10'h031, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    e = model_read(1'b0, 10'h031);
    checks++; if (r !== e) begin errors++; $display("FAIL intstat_read: got %h want %h", r, e); end
    checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL intr_clear: got %b want 0", bus.intr); end
    pulse_ev(8'h04);
    spi_frame(1'b0, 10'h031, 1'b0, 8'h00, 8, 0, 8'h01, r, b1, b2);
    e = model_read(1'b0, 10'h031);
    intstat_m = 8'h01;
    checks++; if (r !== e) begin errors++; $display("FAIL intstat_read_race: got %h want %h", r, e); end
    checks++; if (b2 !== 1'b0 || bus.intr !== 1'b1)
      begin errors++; $display("FAIL set_wins_intr: got dropped=%b intr=%b want 0 1", b2, bus.intr); end
    spi_frame(1'b0, 10'h031, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    e = model_read(1'b0, 10'h031);
    checks++; if (r !== e) begin errors++; $display("FAIL set_wins_value: got %h want %h", r, e); end
    n0 = wr_cnt;
    spi_frame(1'b0, 10'h031, 1'b1, 8'hC0, 8, 0, 8'h00, r, b1, b2);
    model_write(1'b0, 10'h031, 8'hC0);
    checks++; if (wr_cnt !== n0 + 1 || bus.intr !== 1'b1)
      begin errors++; $display("FAIL intstat_write: got pulses=%0d intr=%b want 1 1", wr_cnt - n0, bus.intr); end
    spi_frame(1'b0, 10'h031, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    e = model_read(1'b0, 10'h031);
    checks++; if (r !== e) begin errors++; $display("FAIL intstat_written_value: got %h want %h", r, e); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] cmd; logic [7:0] r, e; bit b1, b2; int n0;
    pulse_ev(8'h10);
    cmd = {1'b1, 10'h3FF, 1'b1, 4'b0000};
    bus.cs = 1'b0;
    #(2*HALF);
    for (int i = 0; i < 5; i++) begin
      bus.sdi = cmd[15-i];
      #HALF bus.sck = 1'b1;
      #HALF bus.sck = 1'b0;
    end
    #7 rst_n = 1'b0;
    #1;
    checks++; if ({bus.sdo, bus.intr, bus.wr_valid, bus.wr_long, bus.wr_addr, bus.wr_data} !== 22'h0)
      begin errors++; $display("FAIL midreset_outputs: got sdo=%b intr=%b v=%b l=%b a=%h d=%h want all 0",
        bus.sdo, bus.intr, bus.wr_valid, bus.wr_long, bus.wr_addr, bus.wr_data); end
    #30 rst_n = 1'b1;
    intstat_m = 8'h00;
    wq_l.delete(); wq_a.delete();
    n0 = wr_cnt;
    for (int i = 5; i < 16; i++) begin
      bus.sdi = cmd[15-i];
      #HALF bus.sck = 1'b1;
      #HALF bus.sck = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      bus.sdi = i[0];
      #HALF bus.sck = 1'b1;
      #HALF bus.sck = 1'b0;
    end
    #HALF bus.cs = 1'b1;
    #(3*HALF);
    checks++; if (wr_cnt !== n0 || bus.intr !== 1'b0)
      begin errors++; $display("FAIL midreset_no_resume: got pulses=%0d intr=%b want 0 0", wr_cnt - n0, bus.intr); end
    spi_frame(1'b1, 10'h2A5, 1'b1, 8'h77, 8, 0, 8'h00, r, b1, b2);
    model_write(1'b1, 10'h2A5, 8'h77);
    checks++; if (wr_cnt !== n0 + 1 || {wr_l_seen, wr_a_seen, wr_d_seen} !== {1'b1, 10'h2A5, 8'h77})
      begin errors++; $display("FAIL postreset_write: got n=%0d l=%b a=%h d=%h want 1 1 2a5 77", wr_cnt - n0, wr_l_seen, wr_a_seen, wr_d_seen); end
    spi_frame(1'b1, 10'h2A5, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
    e = model_read(1'b1, 10'h2A5);
    checks++; if (r !== e) begin errors++; $display("FAIL postreset_read: got %h want %h", r, e); end
  endtask

  task automatic test_extra_sck;
    logic [7:0] r, e; bit b1, b2; int n0;
    n0 = wr_cnt;
    spi_frame(1'b0, 10'h020, 1'b1, 8'h4B, 8, 20, 8'h00, r, b1, b2);
    model_write(1'b0, 10'h020, 8'h4B);
    checks++; if (wr_cnt !== n0 + 1) begin errors++; $display("FAIL extra_single_commit: got %0d want 1", wr_cnt - n0); end
    spi_frame(1'b0, 10'h020, 1'b0, 8'h00, 8, 20, 8'h00, r, b1, b2);
    e = model_read(1'b0, 10'h020);
    checks++; if (r !== e) begin errors++; $display("FAIL extra_read: got %h want %h", r, e); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL done_sdo_zero: got sdo high in DONE want 0"); end
  endtask

  task automatic test_random;
    logic [7:0] r, e, d, ev; logic [9:0] a; bit lng, b1, b2; int n0, idx;
    for (int it = 0; it < 24; it++) begin
      lng = 1'($urandom_range(0, 1));
      a   = 10'($urandom_range(0, 1023));
      d   = 8'($urandom);
      if (!lng) begin
        a[9:6] = 4'h0;
        if (a[5:0] == 6'h31) a[5:0] = 6'h30;
      end
      n0 = wr_cnt;
      spi_frame(lng, a, 1'b1, d, 8, 0, 8'h00, r, b1, b2);
      model_write(lng, a, d);
      wq_l.push_back(lng); wq_a.push_back(a);
      checks++; if (wr_cnt !== n0 + 1 || {wr_l_seen, wr_a_seen, wr_d_seen} !== {lng, a, d})
        begin errors++; $display("FAIL rnd_write%0d: got n=%0d l=%b a=%h d=%h want 1 %b %h %h", it, wr_cnt - n0, wr_l_seen, wr_a_seen, wr_d_seen, lng, a, d); end
      idx = $urandom_range(0, wq_l.size() - 1);
      spi_frame(wq_l[idx], wq_a[idx], 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
      e = model_read(wq_l[idx], wq_a[idx]);
      checks++; if (r !== e) begin errors++; $display("FAIL rnd_read%0d: got %h want %h", it, r, e); end
      if ($urandom_range(0, 3) == 0) begin
        ev = 8'($urandom_range(1, 255));
        pulse_ev(ev);
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL rnd_intr%0d: got %b want 1", it, bus.intr); end
      end
      if ($urandom_range(0, 3) == 0) begin
        spi_frame(1'b0, 10'h031, 1'b0, 8'h00, 8, 0, 8'h00, r, b1, b2);
        e = model_read(1'b0, 10'h031);
        checks++; if (r !== e || bus.intr !== 1'b0)
          begin errors++; $display("FAIL rnd_intstat%0d: got %h intr=%b want %h intr=0", it, r, bus.intr, e); end
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_short_write_read();
    test_long_write_read();
    test_abort_write();
    test_intstat();
    test_reset_mid_frame();
    test_extra_sck();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
